// File: rtl/fwu_frame_checker.sv
// rtl/fwu_frame_checker.sv - firmware-update frame hunter, payload forwarder and CRC-32 checker
module fwu_frame_checker #(
    parameter logic [7:0] SOF_BYTE       = 8'hA5,
    parameter int         MAX_LEN        = 1024,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        abort,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_last,
    input  logic        out_ready,
    output logic        done,
    output logic        frame_ok,
    output logic [1:0]  err_code,
    output logic [15:0] frame_len
);

    localparam int          TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0] MAX_LEN_W = 17'(MAX_LEN);

    typedef enum logic [2:0] {
        S_HUNT, S_LEN0, S_LEN1, S_PAYLOAD, S_CRC, S_RESULT
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   crc_q, crc_d, rx_crc_q, rx_crc_d;
    logic [15:0]   len_q, len_d, rem_q, rem_d, frame_len_q, frame_len_d;
    logic [1:0]    idx_q, idx_d, err_q, err_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          done_q, done_d, ok_q, ok_d;
    logic          in_ready_c, accept;

    // Reflected IEEE 802.3 CRC-32, one byte per call.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // in_ready is masked by reset so every output reads 0 while rst_n is low.
    assign in_ready = in_ready_c & rst_n;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        rx_crc_d    = rx_crc_q;
        len_d       = len_q;
        rem_d       = rem_q;
        idx_d       = idx_q;
        tmo_d       = tmo_q;
        done_d      = 1'b0;
        ok_d        = 1'b0;
        err_d       = 2'd0;
        frame_len_d = frame_len_q;
        in_ready_c  = 1'b0;
        out_valid   = 1'b0;
        out_data    = 8'h00;
        out_last    = 1'b0;

        case (state_q)
            S_HUNT: begin
                in_ready_c = 1'b1;
                tmo_d      = '0;
                if (accept && in_data == SOF_BYTE) begin
                    state_d = S_LEN0;
                    crc_d   = 32'hFFFFFFFF;
                end
            end
            S_LEN0: begin
                in_ready_c = 1'b1;
                if (accept) begin
                    len_d[7:0] = in_data;
                    state_d    = S_LEN1;
                end
            end
            S_LEN1: begin
                in_ready_c = 1'b1;
                if (accept) begin
                    len_d[15:8] = in_data;
                    rem_d       = len_d;
                    if (len_d == 16'd0 || {1'b0, len_d} > MAX_LEN_W) begin
                        state_d = S_RESULT;
                        done_d  = 1'b1;
                        err_d   = 2'd2;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                in_ready_c = out_ready;
                out_valid  = in_valid;
                out_data   = in_data;
                out_last   = (rem_q == 16'd1);
                if (accept) begin
                    crc_d = crc32_byte(crc_q, in_data);
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        state_d = S_CRC;
                        idx_d   = 2'd0;
                    end
                end
            end
            S_CRC: begin
                in_ready_c = 1'b1;
                if (accept) begin
                    rx_crc_d = {in_data, rx_crc_q[31:8]};
                    idx_d    = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = S_RESULT;
                        done_d  = 1'b1;
                        err_d   = (rx_crc_d == ~crc_q) ? 2'd0 : 2'd1;
                    end
                end
            end
            default: begin
                state_d = S_HUNT;
            end
        endcase

        // An accepted byte on the expiry cycle clears the counter instead of timing out.
        if (state_q inside {S_LEN0, S_LEN1, S_PAYLOAD, S_CRC}) begin
            if (accept) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
                tmo_d   = '0;
                state_d = S_RESULT;
                done_d  = 1'b1;
                err_d   = 2'd3;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end

        if (done_d) begin
            ok_d        = (err_d == 2'd0);
            frame_len_d = len_d;
        end

        if (abort) begin
            state_d     = S_HUNT;
            crc_d       = 32'hFFFFFFFF;
            tmo_d       = '0;
            done_d      = 1'b0;
            ok_d        = 1'b0;
            err_d       = 2'd0;
            frame_len_d = frame_len_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_HUNT;
            crc_q       <= 32'hFFFFFFFF;
            rx_crc_q    <= 32'h0;
            len_q       <= 16'h0;
            rem_q       <= 16'h0;
            idx_q       <= 2'd0;
            tmo_q       <= '0;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
            err_q       <= 2'd0;
            frame_len_q <= 16'h0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            rx_crc_q    <= rx_crc_d;
            len_q       <= len_d;
            rem_q       <= rem_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            done_q      <= done_d;
            ok_q        <= ok_d;
            err_q       <= err_d;
            frame_len_q <= frame_len_d;
        end
    end

    assign done      = done_q;
    assign frame_ok  = ok_q;
    assign err_code  = err_q;
    assign frame_len = frame_len_q;

endmodule

// File: tb/tb_fwu_frame_checker.sv
// tb/tb_fwu_frame_checker.sv - directed self-checking bench for fwu_frame_checker
module tb_fwu_frame_checker;

    localparam int T = 20;

    logic        clk = 1'b0, rst_n = 1'b0, abort = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, out_valid, out_last, done, frame_ok;
    logic [7:0]  out_data;
    logic [1:0]  err_code;
    logic [15:0] frame_len;

    int   total = 0, bad = 0, done_cnt = 0, d0;
    bit   tog_en = 1'b0;
    logic [7:0] got_q[$];
    logic       got_last[$];

    fwu_frame_checker #(.SOF_BYTE(8'hA5), .MAX_LEN(16), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .done(done), .frame_ok(frame_ok), .err_code(err_code), .frame_len(frame_len)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        if (out_valid && out_ready) begin
            got_q.push_back(out_data);
            got_last.push_back(out_last);
        end
        if (done) done_cnt++;
    end

    initial forever begin
        @(posedge clk);
        #2;
        if (tog_en) out_ready = ~out_ready;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL send_ready got=0 required=1 byte=%h", b);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int first, input int last, input logic [7:0] crc3);
        logic [7:0] f [16];
        f = '{8'hA5, 8'h09, 8'h00, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
              8'h36, 8'h37, 8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
        f[15] = crc3;
        for (int i = first; i <= last; i++) send(f[i]);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (done !== 1'b0)        begin bad++; $display("FAIL rst_done got=%b required=0", done); end
        total++; if (in_ready !== 1'b0)    begin bad++; $display("FAIL rst_in_ready got=%b required=0", in_ready); end
        total++; if (frame_len !== 16'd0)  begin bad++; $display("FAIL rst_frame_len got=%0d required=0", frame_len); end
        total++; if (out_valid !== 1'b0)   begin bad++; $display("FAIL rst_out_valid got=%b required=0", out_valid); end
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1)    begin bad++; $display("FAIL hunt_in_ready got=%b required=1", in_ready); end
        total++; if (err_code !== 2'd0)    begin bad++; $display("FAIL rst_err got=%0d required=0", err_code); end
        @(posedge clk); #1;
    endtask

    task automatic test_good;
        got_q.delete(); got_last.delete(); d0 = done_cnt;
        send_frame(0, 14, 8'hCB);
        total++; if (done !== 1'b0)        begin bad++; $display("FAIL good_early_done got=%b required=0", done); end
        send(8'hCB);
        total++; if (done !== 1'b1)        begin bad++; $display("FAIL good_done got=%b required=1", done); end
        total++; if (frame_ok !== 1'b1)    begin bad++; $display("FAIL good_ok got=%b required=1", frame_ok); end
        total++; if (err_code !== 2'd0)    begin bad++; $display("FAIL good_err got=%0d required=0", err_code); end
        total++; if (frame_len !== 16'd9)  begin bad++; $display("FAIL good_len got=%0d required=9", frame_len); end
        @(posedge clk); #1;
        total++; if (done !== 1'b0 || done_cnt != d0 + 1) begin bad++; $display("FAIL good_pulse got=%b/%0d required=0/%0d", done, done_cnt - d0, 1); end
        total++; if (got_q.size() != 9)    begin bad++; $display("FAIL good_count got=%0d required=9", got_q.size()); end
        for (int i = 0; i < 9 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== 8'(8'h31 + i) || got_last[i] !== (i == 8)) begin
                bad++; $display("FAIL good_byte%0d got=%h/%b required=%h/%b", i, got_q[i], got_last[i], 8'(8'h31 + i), i == 8);
            end
        end
    endtask

    task automatic test_bad_crc;
        got_q.delete(); got_last.delete();
        send_frame(0, 15, 8'hCA);
        total++; if (done !== 1'b1 || frame_ok !== 1'b0 || err_code !== 2'd1) begin
            bad++; $display("FAIL badcrc got=%b/%b/%0d required=1/0/1", done, frame_ok, err_code); end
        total++; if (got_q.size() != 9)    begin bad++; $display("FAIL badcrc_count got=%0d required=9", got_q.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_garbage;
        d0 = done_cnt;
        send(8'h00); send(8'hFF); send(8'h5A);
        send_frame(0, 15, 8'hCB);
        total++; if (done !== 1'b1 || frame_ok !== 1'b1 || err_code !== 2'd0) begin
            bad++; $display("FAIL garbage got=%b/%b/%0d required=1/1/0", done, frame_ok, err_code); end
        @(posedge clk); #1;
        total++; if (done_cnt != d0 + 1)   begin bad++; $display("FAIL garbage_cnt got=%0d required=1", done_cnt - d0); end
    endtask

    task automatic test_bad_len;
        send(8'hA5); send(8'h00); send(8'h00);
        total++; if (done !== 1'b1 || frame_ok !== 1'b0 || err_code !== 2'd2 || frame_len !== 16'd0) begin
            bad++; $display("FAIL len0 got=%b/%b/%0d/%0d required=1/0/2/0", done, frame_ok, err_code, frame_len); end
        @(posedge clk); #1;
        got_q.delete();
        send(8'hA5); send(8'h11); send(8'h00);
        total++; if (done !== 1'b1 || err_code !== 2'd2 || frame_len !== 16'd17) begin
            bad++; $display("FAIL lenbig got=%b/%0d/%0d required=1/2/17", done, err_code, frame_len); end
        send(8'h31); send(8'h32);
        total++; if (got_q.size() != 0)    begin bad++; $display("FAIL lenbig_payload got=%0d required=0", got_q.size()); end
    endtask

    task automatic test_timeout;
        send_frame(0, 6, 8'hCB);
        repeat (T - 1) @(posedge clk);
        #1;
        total++; if (done !== 1'b0)        begin bad++; $display("FAIL tmo_early got=%b required=0", done); end
        @(posedge clk); #1;
        total++; if (done !== 1'b1 || frame_ok !== 1'b0 || err_code !== 2'd3) begin
            bad++; $display("FAIL tmo got=%b/%b/%0d required=1/0/3", done, frame_ok, err_code); end
        @(posedge clk); #1;
        send_frame(0, 15, 8'hCB);
        total++; if (done !== 1'b1 || frame_ok !== 1'b1) begin bad++; $display("FAIL tmo_next got=%b/%b required=1/1", done, frame_ok); end
        @(posedge clk); #1;
    endtask

    task automatic test_expiry;
        d0 = done_cnt;
        send_frame(0, 6, 8'hCB);
        repeat (T - 1) @(posedge clk);
        #1;
        send_frame(7, 15, 8'hCB);
        total++; if (done !== 1'b1 || frame_ok !== 1'b1 || err_code !== 2'd0) begin
            bad++; $display("FAIL expiry got=%b/%b/%0d required=1/1/0", done, frame_ok, err_code); end
        @(posedge clk); #1;
        total++; if (done_cnt != d0 + 1)   begin bad++; $display("FAIL expiry_cnt got=%0d required=1", done_cnt - d0); end
    endtask

    task automatic test_toggle;
        got_q.delete(); got_last.delete();
        tog_en = 1'b1;
        send_frame(0, 15, 8'hCB);
        total++; if (done !== 1'b1 || frame_ok !== 1'b1) begin bad++; $display("FAIL toggle got=%b/%b required=1/1", done, frame_ok); end
        tog_en = 1'b0;
        @(posedge clk); #3; out_ready = 1'b1;
        total++; if (got_q.size() != 9)    begin bad++; $display("FAIL toggle_count got=%0d required=9", got_q.size()); end
        for (int i = 0; i < 9 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== 8'(8'h31 + i)) begin bad++; $display("FAIL toggle_byte%0d got=%h required=%h", i, got_q[i], 8'(8'h31 + i)); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abort;
        d0 = done_cnt;
        send_frame(0, 5, 8'hCB);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (done_cnt != d0 || frame_len !== 16'd9) begin
            bad++; $display("FAIL abort got=%0d/%0d required=0/9", done_cnt - d0, frame_len); end
        send_frame(0, 15, 8'hCB);
        total++; if (done !== 1'b1 || frame_ok !== 1'b1) begin bad++; $display("FAIL abort_next got=%b/%b required=1/1", done, frame_ok); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        send_frame(0, 13, 8'hCB);
        #2; rst_n = 1'b0;
        #1;
        total++; if (done !== 1'b0 || frame_ok !== 1'b0 || err_code !== 2'd0) begin
            bad++; $display("FAIL rstmid_res got=%b/%b/%0d required=0/0/0", done, frame_ok, err_code); end
        total++; if (frame_len !== 16'd0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++; $display("FAIL rstmid_out got=%0d/%b/%b required=0/0/0", frame_len, out_valid, in_ready); end
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
        send_frame(0, 15, 8'hCB);
        total++; if (done !== 1'b1 || frame_ok !== 1'b1) begin bad++; $display("FAIL rstmid_next got=%b/%b required=1/1", done, frame_ok); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_good;
        test_bad_crc;
        test_garbage;
        test_bad_len;
        test_timeout;
        test_expiry;
        test_toggle;
        test_abort;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fwu_frame_checker.md
Name: fwu_frame_checker

Overview:
Receive-side framer and integrity checker for the firmware-update byte stream arriving from the UART/SPI front end. Hunts for a start-of-frame byte, reads a 16-bit length, forwards payload bytes downstream, and checks the 4-byte CRC-32 trailer. The CRC is IEEE 802.3 reflected (poly 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF), computed byte-wise by an internal engine. Ends each frame with a one-cycle result pulse consumed by the update controller.

Parameters:
SOF_BYTE, 8'hA5, start-of-frame marker
MAX_LEN, 1024, largest legal payload length in bytes (1..65535)
TIMEOUT_CYCLES, 100000, idle cycles allowed between accepted bytes inside a frame (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
abort  in  1  synchronous flush; return to hunt, no result pulse
in_valid  in  1  input byte valid
in_data  in  8  input byte
in_ready  out  1  input byte accepted when in_valid & in_ready
out_valid  out  1  payload byte valid
out_data  out  8  payload byte
out_last  out  1  marks final payload byte of frame
out_ready  in  1  downstream accepts payload byte
done  out  1  one-cycle frame-complete pulse
frame_ok  out  1  valid with done: 1 = CRC matched
err_code  out  2  valid with done: 0 ok, 1 CRC mismatch, 2 bad length, 3 timeout
frame_len  out  16  length of last framed payload, held until next done

Behaviour:
- Reset (async, rst_n low): state HUNT, crc=0xFFFFFFFF, all outputs 0, frame_len=0, timeout counter 0.
- Frame: SOF, LEN_LO, LEN_HI, LEN payload bytes, CRC0..CRC3 (LSB first). CRC covers payload only.
- States: HUNT, LEN0, LEN1, PAYLOAD, CRC, RESULT.
- HUNT: in_ready=1; bytes other than SOF_BYTE discarded; SOF -> LEN0; crc reinitialised to 0xFFFFFFFF.
- LEN0/LEN1: in_ready=1; capture low then high byte. After LEN1: LEN==0 or LEN>MAX_LEN -> RESULT with err 2; else -> PAYLOAD.
- PAYLOAD: combinational pass-through, in_ready=out_ready, out_valid=in_valid, out_data=in_data. Each handshake updates crc and decrements remaining count. out_last=1 when remaining==1. The last byte -> CRC.
- CRC: in_ready=1; shift in 4 bytes into rx_crc[31:0] little-endian. After the 4th byte -> RESULT.
- RESULT: one cycle. done=1, frame_ok=(rx_crc==~crc) and no earlier error, err_code set. frame_len is updated, including for err 2. Then -> HUNT. in_ready=0 in RESULT.
- Latency: done asserts exactly 1 cycle after the handshake of CRC3 (or LEN_HI for length error).
- Timeout: counter runs in LEN0, LEN1, PAYLOAD, CRC; cleared on every accepted byte. Reaching TIMEOUT_CYCLES -> RESULT with err 3. An accepted byte in the same cycle as expiry wins: the byte is taken and the counter cleared. In PAYLOAD, stall from out_ready=0 also counts toward timeout.
- abort: highest priority over all states including RESULT. Next state HUNT, done suppressed, crc reinitialised. frame_len unchanged.
- SOF bytes inside LEN/PAYLOAD/CRC are ordinary data (no resync).
- Outputs done/frame_ok/err_code are registered; frame_ok and err_code read 0 when done=0.

Test Plan:
- SOF A5, LEN 09 00, payload "123456789" (31..39), CRC 26 39 F4 CB -> 9 payload bytes out, out_last on 0x39, done=1 ok=1 err=0 frame_len=9, one cycle after CB.
- Same frame with CRC byte CB changed to CA -> payload still forwarded, done with ok=0 err=1.
- Garbage 00 FF 5A then valid frame -> garbage discarded, single ok result; LEN 00 00 -> done err=2 frame_len=0; LEN = MAX_LEN+1 -> err=2, no payload out.
- Stall after 4 payload bytes for TIMEOUT_CYCLES -> done err=3, then a fresh valid frame passes ok. Also: byte arriving exactly on the expiry cycle -> accepted, no timeout.
- out_ready toggling 1010... during payload -> no byte lost or duplicated, ok=1. abort mid-payload -> no done, next frame ok. rst_n low mid-CRC -> all outputs 0 immediately.
